// File: rtl/ring_phase_decoder.sv
// Decodes a rotating one-hot ring pattern to a phase index and locks onto its rotation.
// Counts out-of-sequence steps while locked. The error count saturates at all-ones.
module ring_phase_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         ring_in,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     valid,
    output logic                     locked,
    output logic                     wrap,
    output logic                     err,
    output logic [ERR_CNT_W-1:0]     err_count,
    output logic [1:0]               state_dbg
);
    localparam int PW = $clog2(WIDTH);
    localparam int SW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SW-1:0]        streak_q, streak_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    logic [PW:0]   hot_cnt;
    logic [PW-1:0] idx;
    logic          onehot;
    logic [PW-1:0] expected;
    logic          in_seq;
    logic [SW-1:0] streak_inc;

    // The index OR-reduction is only meaningful when exactly one bit is hot.
    always_comb begin
        hot_cnt = '0;
        idx     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                hot_cnt = hot_cnt + (PW+1)'(1);
                idx     = idx | PW'(i);
            end
        end
    end

    assign onehot     = (hot_cnt == (PW+1)'(1));
    assign expected   = phase_q + PW'(1);
    assign in_seq     = onehot && (idx == expected);
    assign streak_inc = streak_q + SW'(1);

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        phase_d  = phase_q;
        valid_d  = valid_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        if (enable) begin
            valid_d = onehot;
            if (onehot) begin
                phase_d = idx;
            end
            case (state_q)
                HUNT: begin
                    if (onehot) begin
                        state_d  = ACQUIRE;
                        streak_d = SW'(1);
                    end
                end
                ACQUIRE: begin
                    if (!onehot) begin
                        state_d  = HUNT;
                        streak_d = '0;
                    end else if (in_seq) begin
                        streak_d = streak_inc;
                        if (streak_inc >= SW'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        streak_d = SW'(1);
                    end
                end
                LOCKED: begin
                    if (in_seq) begin
                        wrap_d = (idx == '0);
                    end else begin
                        err_d    = 1'b1;
                        state_d  = HUNT;
                        streak_d = '0;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = HUNT;
                    streak_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= HUNT;
            streak_q <= '0;
            phase_q  <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            phase_q  <= phase_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign phase     = phase_q;
    assign valid     = valid_q;
    assign locked    = (state_q == LOCKED);
    assign wrap      = wrap_q;
    assign err       = err_q;
    assign err_count = cnt_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_ring_phase_decoder.sv
// Directed bench for ring_phase_decoder (WIDTH=4, LOCK_COUNT=2, ERR_CNT_W=2).
// Each applied vector pushes its hand-computed response. The negedge monitor pops and compares it.
module tb_ring_phase_decoder;
    logic       clock;
    logic       reset;
    logic       enable;
    logic [3:0] ring_in;
    logic [1:0] phase;
    logic       valid;
    logic       locked;
    logic       wrap;
    logic       err;
    logic [1:0] err_count;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];
    logic [7:0] act;

    assign act = {phase, valid, locked, wrap, err, err_count};

    ring_phase_decoder #(
        .WIDTH(4),
        .LOCK_COUNT(2),
        .ERR_CNT_W(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .ring_in(ring_in),
        .phase(phase),
        .valid(valid),
        .locked(locked),
        .wrap(wrap),
        .err(err),
        .err_count(err_count),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Fields, in bit order: phase[7:6] valid[5] locked[4] wrap[3] err[2] err_count[1:0].
    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got ph=%b v=%b l=%b w=%b e=%b cnt=%b, expected ph=%b v=%b l=%b w=%b e=%b cnt=%b",
                     nm, got[7:6], got[5], got[4], got[3], got[2], got[1:0],
                     want[7:6], want[5], want[4], want[3], want[2], want[1:0]);
        end
    endtask

    // driver
    task automatic apply(input logic en, input logic [3:0] r, input logic [1:0] ph,
                         input logic v, input logic l, input logic w, input logic e,
                         input logic [1:0] c, input string nm);
        @(negedge clock);
        enable  = en;
        ring_in = r;
        @(posedge clock);
        exp_q.push_back({ph, v, l, w, e, c});
        name_q.push_back(nm);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            check(name_q.pop_front(), act, exp_q.pop_front());
        end
    end

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        ring_in = 4'b0000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_state", act, 8'b0);
        reset = 1'b1;

        // invalid patterns straight out of reset
        apply(1, 4'b0000, 2'd0, 0, 0, 0, 0, 2'd0, "inv_0000");
        apply(1, 4'b0011, 2'd0, 0, 0, 0, 0, 2'd0, "inv_0011");
        apply(1, 4'b1111, 2'd0, 0, 0, 0, 0, 2'd0, "inv_1111");

        // lock and wrap
        apply(1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd0, "acq_p0");
        apply(1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd0, "lock_p1");
        apply(1, 4'b0100, 2'd2, 1, 1, 0, 0, 2'd0, "run_p2");
        apply(1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd0, "run_p3");
        apply(1, 4'b0001, 2'd0, 1, 1, 1, 0, 2'd0, "wrap_p0");
        apply(1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd0, "post_wrap_p1");

        // skipped phase while locked, relock, then a repeated value
        apply(1, 4'b1000, 2'd3, 1, 0, 0, 1, 2'd1, "skip_err");
        apply(1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd1, "reacq_p0");
        apply(1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd1, "relock_p1");
        apply(1, 4'b0010, 2'd1, 1, 0, 0, 1, 2'd2, "repeat_err");

        // enable gating while locked at phase 3
        apply(1, 4'b0100, 2'd2, 1, 0, 0, 0, 2'd2, "acq_p2");
        apply(1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd2, "lock_p3");
        for (int i = 0; i < 3; i++) begin
            apply(0, 4'b0110, 2'd3, 1, 1, 0, 0, 2'd2, "gated_hold");
        end
        apply(1, 4'b0001, 2'd0, 1, 1, 1, 0, 2'd2, "gated_wrap");

        // multi-hot while locked, ACQUIRE out-of-sequence restart, zero while locked
        apply(1, 4'b0011, 2'd0, 0, 0, 0, 1, 2'd3, "multihot_err");
        apply(1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd3, "acq2_p0");
        apply(1, 4'b0100, 2'd2, 1, 0, 0, 0, 2'd3, "acq_oos");
        apply(1, 4'b1000, 2'd3, 1, 1, 0, 0, 2'd3, "lock_after_oos");
        apply(1, 4'b0000, 2'd3, 0, 0, 0, 1, 2'd3, "zero_err_sat");

        // ACQUIRE falls back to HUNT on an invalid pattern, without err
        apply(1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd3, "acq3_p0");
        apply(1, 4'b1111, 2'd0, 0, 0, 0, 0, 2'd3, "acq_invalid");
        apply(1, 4'b0010, 2'd1, 1, 0, 0, 0, 2'd3, "hunt_p1");
        apply(1, 4'b0100, 2'd2, 1, 1, 0, 0, 2'd3, "lock_p2");
        apply(1, 4'b0100, 2'd2, 1, 0, 0, 1, 2'd3, "sat_hold_err");

        // relock to phase 2, then reset asynchronously between edges
        apply(1, 4'b1000, 2'd3, 1, 0, 0, 0, 2'd3, "acq_p3");
        apply(1, 4'b0001, 2'd0, 1, 1, 0, 0, 2'd3, "lock_p0_nowrap");
        apply(1, 4'b0010, 2'd1, 1, 1, 0, 0, 2'd3, "run2_p1");
        apply(1, 4'b0100, 2'd2, 1, 1, 0, 0, 2'd3, "run2_p2");
        @(negedge clock);
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        check("async_reset", act, 8'b0);
        @(negedge clock);
        reset = 1'b1;
        apply(1, 4'b0001, 2'd0, 1, 0, 0, 0, 2'd0, "post_reset_p0");

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d responses still pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
